// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial instruction fetch unit.
// Assembles a little-endian 32-bit instruction from four byte reads through a
// memory arbiter and hands it to IF/ID. A branch aborts the fetch in progress,
// and a low rdy freezes the unit.
// Optional feature: define ICACHE_EN to add a 64-entry direct-mapped
// instruction cache (index pc[7:2], tag pc[31:8]).
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_i,
  input  logic        branch_enable_i,
  input  logic        stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [1:0]  cnt_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] asm_reg;
  logic        cache_hit;
  logic [31:0] cache_word;

`ifdef ICACHE_EN
  logic [31:0] cache_data [0:63];
  logic [23:0] cache_tag  [0:63];
  logic [63:0] cache_valid_reg;
  logic [5:0]  lookup_idx;
  logic [5:0]  fill_idx;
  logic        fill_en;

  assign lookup_idx = pc_i[7:2];
  assign fill_idx   = fetch_pc_reg[7:2];
  assign cache_hit  = cache_valid_reg[lookup_idx] && (cache_tag[lookup_idx] == pc_i[31:8]);
  assign cache_word = cache_data[lookup_idx];
  // Fill only on the final byte of a fetch that is not being aborted or frozen.
  assign fill_en    = !rst && rdy && !branch_enable_i &&
                      (state_reg == S_WAIT) && (cnt_reg == 2'd3);

  // Valid bits: cleared on reset, set when an entry is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_reg <= '0;
    end else if (fill_en) begin
      cache_valid_reg[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage, written with the completed word on fill.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      cache_data[fill_idx] <= {mem_rdata_i, asm_reg[23:0]};
      cache_tag[fill_idx]  <= fetch_pc_reg[31:8];
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_word = 32'h0000_0000;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: branch beats everything, rdy low holds the state.
  always_comb begin
    state_next = state_reg;
    if (branch_enable_i) begin
      state_next = S_IDLE;
    end else if (rdy) begin
      case (state_reg)
        S_IDLE: state_next = cache_hit ? S_DONE : S_REQ;
        S_REQ:  state_next = mem_gnt_i ? S_WAIT : S_REQ;
        S_WAIT: state_next = (cnt_reg == 2'd3) ? S_DONE : S_REQ;
        S_DONE: state_next = stall_i ? S_DONE : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: fetch address, byte counter and instruction assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= 2'd0;
      fetch_pc_reg <= 32'h0000_0000;
      asm_reg      <= 32'h0000_0000;
    end else if (branch_enable_i) begin
      cnt_reg <= 2'd0;
      asm_reg <= 32'h0000_0000;
    end else if (rdy) begin
      case (state_reg)
        S_IDLE: begin
          fetch_pc_reg <= pc_i;
          cnt_reg      <= 2'd0;
          if (cache_hit) begin
            asm_reg <= cache_word;
          end
        end
        S_WAIT: begin
          asm_reg[{cnt_reg, 3'b000} +: 8] <= mem_rdata_i;
          if (cnt_reg != 2'd3) begin
            cnt_reg <= cnt_reg + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; reset forces the idle-safe values.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_addr_o   = 32'h0000_0000;
    inst_valid_o = 1'b0;
    stall_req_o  = 1'b1;
    if (!rst) begin
      if (state_reg == S_REQ) begin
        mem_req_o  = rdy;
        mem_addr_o = fetch_pc_reg + {30'd0, cnt_reg};
      end
      if (state_reg == S_DONE) begin
        inst_valid_o = !branch_enable_i;
        stall_req_o  = stall_i;
      end
    end
  end

  assign inst_o    = asm_reg;
  assign inst_pc_o = fetch_pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch. Expected request addresses
// and instructions are queued when a fetch is started and popped when the DUT
// issues a granted request or hands off an instruction.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_i;
  logic        branch_enable_i;
  logic        stall_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stall_req_o;

`ifdef ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int stall_low_cnt = 0;
  int handoffs = 0;
  bit mon_en = 1'b0;

  logic [31:0] addr_q[$];
  logic [63:0] inst_q[$];

  inst_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i),
    .branch_enable_i(branch_enable_i), .stall_i(stall_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x13,0x00,0x00,0x00 at 0..3, a hashed byte elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a == 32'd0) return 8'h13;
    if (a < 32'd4) return 8'h00;
    return (a[7:0] * 8'd37 + 8'd11) ^ a[31:24];
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  task automatic push_fetch(input logic [31:0] pc, input bit with_addrs);
    if (with_addrs)
      for (int i = 0; i < 4; i++) addr_q.push_back(pc + i);
    inst_q.push_back({pc, exp_inst(pc)});
  endtask

  // Memory responder: byte returns one cycle after an accepted request.
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) mem_rdata_i <= mem_byte(mem_addr_o);
    else mem_rdata_i <= 8'hEE;
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req_o) req_cycles++;
      if (!stall_req_o) stall_low_cnt++;
      if (mem_req_o && mem_gnt_i) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL req_addr: unexpected request to %h", mem_addr_o);
        end else begin
          logic [31:0] ea;
          ea = addr_q.pop_front();
          if (mem_addr_o !== ea) begin
            errors++;
            $display("FAIL req_addr: got %h expected %h", mem_addr_o, ea);
          end
        end
      end
      if (inst_valid_o && !stall_i) begin
        handoffs++;
        checks++;
        if (inst_q.size() == 0) begin
          errors++;
          $display("FAIL handoff: unexpected inst %h at pc %h", inst_o, inst_pc_o);
        end else begin
          logic [63:0] ei;
          ei = inst_q.pop_front();
          if ({inst_pc_o, inst_o} !== ei) begin
            errors++;
            $display("FAIL handoff: got pc %h inst %h expected pc %h inst %h",
                     inst_pc_o, inst_o, ei[63:32], ei[31:0]);
          end
        end
      end
    end
  end

  task automatic recover();
    rst = 1'b1; rdy = 1'b0; branch_enable_i = 1'b0; stall_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_q.delete();
    inst_q.delete();
  endtask

  // Runs from the IDLE cycle (k=0) until inst_valid_o is seen; lat = cycle.
  task automatic wait_valid(input int max_cycles, output int lat);
    lat = -1;
    for (int k = 0; k <= max_cycles; k++) begin
      @(negedge clk);
      if (inst_valid_o) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout: inst_valid_o not seen within %0d cycles", max_cycles);
      recover();
    end
  endtask

  // After the handoff cycle the DUT returns to IDLE; hold it there.
  task automatic park();
    @(posedge clk); #1;
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; branch_enable_i = 1'b1; stall_i = 1'b0;
    pc_i = 32'h1234_5678; mem_gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    checks += 6;
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid_o); end
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_req_o); end
    if (stall_req_o !== 1'b1) begin errors++; $display("FAIL rst_stall_req: got %b expected 1", stall_req_o); end
    if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst_o); end
    if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc_o); end
    if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_addr_o); end
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b0; branch_enable_i = 1'b0; pc_i = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input logic [31:0] pc, input string name);
    int lat;
    int sl0;
    int h0;
    sl0 = stall_low_cnt; h0 = handoffs;
    push_fetch(pc, 1'b1);
    pc_i = pc; rdy = 1'b1; mem_gnt_i = 1'b1;
    wait_valid(40, lat);
    checks += 2;
    if (lat != 9) begin errors++; $display("FAIL %s_latency: got %0d expected 9", name, lat); end
    if (inst_o !== exp_inst(pc)) begin errors++; $display("FAIL %s_inst: got %h expected %h", name, inst_o, exp_inst(pc)); end
    park();
    checks += 2;
    if (stall_low_cnt - sl0 != 1) begin errors++; $display("FAIL %s_stall_low: got %0d cycles expected 1", name, stall_low_cnt - sl0); end
    if (handoffs - h0 != 1) begin errors++; $display("FAIL %s_handoffs: got %0d expected 1", name, handoffs - h0); end
  endtask

  task automatic test_gnt_gap();
    int lat = -1;
    push_fetch(32'h10, 1'b1);
    pc_i = 32'h10; rdy = 1'b1; mem_gnt_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 8) begin
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h12) begin
          errors++;
          $display("FAIL gap_addr: cycle %0d req %b addr %h expected req 1 addr 00000012", k, mem_req_o, mem_addr_o);
        end
      end
      if (inst_valid_o) begin lat = k; break; end
      @(posedge clk); #1;
      mem_gnt_i = !((k + 1) >= 5 && (k + 1) <= 7);
    end
    mem_gnt_i = 1'b1;
    checks++;
    if (lat != 12) begin errors++; $display("FAIL gap_latency: got %0d expected 12", lat); end
    if (lat < 0) recover(); else park();
  endtask

  task automatic test_branch();
    int lat = -1;
    addr_q.push_back(32'h20);
    addr_q.push_back(32'h21);
    push_fetch(32'h100, 1'b1);
    pc_i = 32'h20; rdy = 1'b1; mem_gnt_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        checks += 2;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL branch_idle_req: got %b expected 0", mem_req_o); end
        if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL branch_valid: got %b expected 0", inst_valid_o); end
      end
      if (k == 6) begin
        checks++;
        if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL branch_new_addr: got %h expected 00000100", mem_addr_o); end
      end
      if (inst_valid_o) begin lat = k; break; end
      @(posedge clk); #1;
      branch_enable_i = ((k + 1) == 4);
      if ((k + 1) == 4) pc_i = 32'h100;
    end
    branch_enable_i = 1'b0;
    checks++;
    if (lat != 14) begin errors++; $display("FAIL branch_latency: got %0d expected 14", lat); end
    if (lat < 0) recover(); else park();
  endtask

  task automatic test_stall();
    int lat;
    int sl0;
    int h0;
    logic [31:0] hold;
    sl0 = stall_low_cnt; h0 = handoffs;
    push_fetch(32'h30, 1'b1);
    pc_i = 32'h30; rdy = 1'b1; mem_gnt_i = 1'b1; stall_i = 1'b1;
    wait_valid(40, lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL stall_latency: got %0d expected 9", lat); end
    hold = exp_inst(32'h30);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks += 3;
      if (inst_o !== hold) begin errors++; $display("FAIL stall_inst_stable: got %h expected %h", inst_o, hold); end
      if (stall_req_o !== 1'b1) begin errors++; $display("FAIL stall_req_hold: got %b expected 1", stall_req_o); end
      if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid_hold: got %b expected 1", inst_valid_o); end
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_req_o !== 1'b0) begin errors++; $display("FAIL stall_release: got stall_req_o %b expected 0", stall_req_o); end
    park();
    checks += 2;
    if (stall_low_cnt - sl0 != 1) begin errors++; $display("FAIL stall_low_cycles: got %0d expected 1", stall_low_cnt - sl0); end
    if (handoffs - h0 != 1) begin errors++; $display("FAIL stall_handoffs: got %0d expected 1", handoffs - h0); end
  endtask

  task automatic test_rdy_freeze();
    int lat = -1;
    push_fetch(32'h50, 1'b1);
    pc_i = 32'h50; rdy = 1'b1; mem_gnt_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 5) begin
        checks += 2;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL freeze_req: cycle %0d got %b expected 0", k, mem_req_o); end
        if (mem_addr_o !== 32'h51) begin errors++; $display("FAIL freeze_addr: cycle %0d got %h expected 00000051", k, mem_addr_o); end
      end
      if (inst_valid_o) begin lat = k; break; end
      @(posedge clk); #1;
      rdy = !((k + 1) >= 3 && (k + 1) <= 5);
    end
    rdy = 1'b1;
    checks++;
    if (lat != 12) begin errors++; $display("FAIL freeze_latency: got %0d expected 12", lat); end
    if (lat < 0) recover(); else park();
  endtask

  task automatic test_reset_mid_fetch();
    int lat = -1;
    addr_q.push_back(32'h40);
    addr_q.push_back(32'h41);
    push_fetch(32'h0, 1'b1);
    pc_i = 32'h40; rdy = 1'b1; mem_gnt_i = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin
        checks += 2;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b expected 0", mem_req_o); end
        if (stall_req_o !== 1'b1) begin errors++; $display("FAIL midrst_stall_req: got %b expected 1", stall_req_o); end
      end
      if (k == 5) begin
        checks += 2;
        if (inst_o !== 32'h0) begin errors++; $display("FAIL midrst_inst: got %h expected 0", inst_o); end
        if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL midrst_inst_pc: got %h expected 0", inst_pc_o); end
      end
      if (k == 6) begin
        checks++;
        if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_first_addr: got %h expected 0", mem_addr_o); end
      end
      if (inst_valid_o) begin lat = k; break; end
      @(posedge clk); #1;
      rst = ((k + 1) == 4);
      branch_enable_i = ((k + 1) == 4);
      rdy = ((k + 1) != 4);
      if ((k + 1) == 4) pc_i = 32'h0;
    end
    rst = 1'b0; branch_enable_i = 1'b0; rdy = 1'b1;
    checks++;
    if (lat != 14) begin errors++; $display("FAIL midrst_latency: got %0d expected 14", lat); end
    if (lat < 0) recover(); else park();
  endtask

  task automatic test_cache_refetch();
    int lat;
    int r0;
    int exp_lat;
    test_basic(32'h4, "fill");
    r0 = req_cycles;
    exp_lat = CACHE ? 1 : 9;
    push_fetch(32'h4, !CACHE);
    pc_i = 32'h4; rdy = 1'b1; mem_gnt_i = 1'b1;
    wait_valid(40, lat);
    checks += 3;
    if (lat != exp_lat) begin errors++; $display("FAIL refetch_latency: got %0d expected %0d", lat, exp_lat); end
    if (inst_o !== exp_inst(32'h4)) begin errors++; $display("FAIL refetch_inst: got %h expected %h", inst_o, exp_inst(32'h4)); end
    if (req_cycles - r0 != (CACHE ? 0 : 4)) begin
      errors++;
      $display("FAIL refetch_req_cycles: got %0d expected %0d", req_cycles - r0, CACHE ? 0 : 4);
    end
    if (lat >= 0) park();
  endtask

  initial begin
    mem_rdata_i = 8'hEE;
    test_reset();
    test_basic(32'h0, "basic");
    test_gnt_gap();
    test_branch();
    test_stall();
    test_basic(32'hFFFF_FFFE, "wrap");
    test_rdy_freeze();
    test_reset_mid_fetch();
    test_cache_refetch();
    repeat (3) @(posedge clk);
    checks += 2;
    if (addr_q.size() != 0) begin errors++; $display("FAIL addr_queue_drain: %0d left expected 0", addr_q.size()); end
    if (inst_q.size() != 0) begin errors++; $display("FAIL inst_queue_drain: %0d left expected 0", inst_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: rdy  input  1  global ready; low freezes all state.
REQ-004 SHALL have port: pc_i  input  32  current program counter from the PC register.
REQ-005 SHALL have port: branch_enable_i  input  1  branch taken; flushes the fetch in progress.
REQ-006 SHALL have port: stall_i  input  1  downstream (IF/ID) cannot accept an instruction.
REQ-007 SHALL have port: mem_req_o  output  1  byte read request to the memory arbiter.
REQ-008 SHALL have port: mem_addr_o  output  32  byte address of the request.
REQ-009 SHALL have port: mem_gnt_i  input  1  arbiter accepts mem_req_o this cycle.
REQ-010 SHALL have port: mem_rdata_i  input  8  read byte, valid exactly one cycle after an accepted request.
REQ-011 SHALL have port: inst_o  output  32  fetched instruction, little-endian.
REQ-012 SHALL have port: inst_pc_o  output  32  address of inst_o.
REQ-013 SHALL have port: inst_valid_o  output  1  inst_o/inst_pc_o valid.
REQ-014 SHALL have port: stall_req_o  output  1  holds the PC register (drives stall_sign[0]).

Function
REQ-015 SHALL implement states IDLE, REQ, WAIT, DONE, with a 2-bit byte counter cnt and a 32-bit fetch_pc.
REQ-016 IDLE: SHALL latch pc_i into fetch_pc, clear cnt, and go to REQ.
REQ-017 REQ: SHALL drive mem_req_o=1 and mem_addr_o=fetch_pc+cnt; on mem_gnt_i=1 go to WAIT, else stay.
REQ-018 WAIT: SHALL write mem_rdata_i into byte cnt of the assembly register (byte 0 = bits 7:0); if cnt==3 go to DONE, else cnt+1 and go to REQ.
REQ-019 DONE: SHALL assert inst_valid_o with inst_o and inst_pc_o=fetch_pc; stay while stall_i=1; go to IDLE when stall_i=0.
REQ-020 SHALL drive mem_req_o only in REQ; mem_addr_o SHALL be 0 elsewhere.
REQ-021 SHALL drive stall_req_o=1 in every state except DONE with stall_i=0, so the PC advances exactly once per delivered instruction.
REQ-022 With mem_gnt_i held high, inst_valid_o SHALL rise exactly 9 cycles after the IDLE cycle; each cycle of gnt low SHALL add one cycle.
REQ-023 Byte address arithmetic SHALL be 32-bit modulo 2^32; fetch_pc+3 SHALL wrap past 0xFFFFFFFF.
REQ-024 branch_enable_i=1 in any state SHALL force IDLE next cycle, clear inst_valid_o, and discard partial bytes and any outstanding byte; this SHALL take priority over stall_i and gnt.
REQ-025 A byte returning after a branch abort SHALL be ignored.
REQ-026 rdy=0 SHALL freeze state, cnt, fetch_pc and outputs, and SHALL force mem_req_o=0; branch_enable_i SHALL still be honoured.

Reset
REQ-027 rst=1 SHALL take priority over all inputs, including rdy and branch_enable_i.
REQ-028 On rst, state SHALL be IDLE, cnt 0, and inst_o, inst_pc_o and mem_addr_o 0x00000000.
REQ-029 On rst, inst_valid_o and mem_req_o SHALL be 0 and stall_req_o SHALL be 1.
REQ-030 Reset mid-fetch SHALL discard all partial data; the first request after release SHALL be to address 0x00000000.

Configuration
REQ-031 Macro ICACHE_EN SHALL, when defined, add a 64-entry direct-mapped instruction cache with index pc[7:2], tag pc[31:8] and one valid bit per entry.
REQ-032 With ICACHE_EN defined, all valid bits SHALL clear on rst.
REQ-033 With ICACHE_EN defined, a hit in IDLE SHALL go directly to DONE with the cached word, giving 1-cycle latency and no memory request.
REQ-034 With ICACHE_EN defined, a miss SHALL follow REQ-016..018 and fill the entry on the WAIT cycle with cnt==3; an aborted fetch SHALL NOT fill.
REQ-035 Without ICACHE_EN, no cache storage SHALL exist and every fetch SHALL go to memory.

Verification
REQ-036 Reset, pc_i=0, gnt=1, bytes 13,00,00,00 -> requests to addresses 0,1,2,3; inst_o=0x00000013 valid at cycle 9; stall_req_o low for exactly one cycle.
REQ-037 gnt low for 3 cycles on byte 2 -> valid at cycle 12; the address holds at fetch_pc+2 throughout.
REQ-038 branch_enable_i pulsed in WAIT with cnt=1 -> IDLE next cycle, no valid; the following fetch uses the new pc_i=0x00000100.
REQ-039 stall_i=1 for 4 cycles in DONE -> inst_o stable and stall_req_o=1 throughout; a single handoff follows.
REQ-040 pc_i=0xFFFFFFFE -> requests to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-041 With ICACHE_EN, refetch of 0x00000004 after a fill -> valid 1 cycle after IDLE and mem_req_o never asserted; without ICACHE_EN -> 9 cycles.
